// File: rtl/jtvigil_colmix_pkg.sv
// Shared types and constants for the jtvigil colour mixer: lookup FSM states,
// palette channel codes, layer bases and transparency codes.
package jtvigil_colmix_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_R  = 3'd1,
    RD_G  = 3'd2,
    RD_B  = 3'd3,
    CAP_B = 3'd4
  } state_e;

  localparam logic [1:0] CH_R    = 2'd0;
  localparam logic [1:0] CH_G    = 2'd1;
  localparam logic [1:0] CH_B    = 2'd2;
  localparam logic [1:0] CH_NONE = 2'd3;

  localparam logic [8:0] OBJ_BASE  = 9'h100;
  localparam logic [8:0] SCR2_BASE = 9'h180;

  localparam logic [3:0] OBJ_TRANSP  = 4'hF;
  localparam logic [3:0] SCR1_TRANSP = 4'h0;

  // Fixed layer priority: opaque obj, then opaque scr1, then scr2 (or its
  // disabled-layer colour when the background is switched off).
  function automatic logic [8:0] pick_index(input logic [7:0] scr1,
                                            input logic [6:0] scr2,
                                            input logic [6:0] obj,
                                            input logic       scr2_en);
    logic [8:0] idx;
    idx = SCR2_BASE;
    if (obj[3:0] != OBJ_TRANSP) begin
      idx = OBJ_BASE | {2'b00, obj};
    end else if (scr1[3:0] != SCR1_TRANSP) begin
      idx = {1'b0, scr1};
    end else if (scr2_en) begin
      idx = SCR2_BASE | {2'b00, scr2};
    end else begin
      idx = SCR2_BASE;
    end
    return idx;
  endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// Dual-port synchronous RAM: port 0 read/write, port 1 read-only, one clock,
// one cycle read latency on both ports (port 0 returns old data on write).
module jtframe_dual_ram #(
  parameter int AW = 11,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic [DW-1:0] data0,
  input  logic [AW-1:0] addr0,
  input  logic          we0,
  output logic [DW-1:0] q0,
  input  logic [AW-1:0] addr1,
  output logic [DW-1:0] q1
);

  logic [DW-1:0] mem_q [0:(2**AW)-1];

  // Port 0: CPU write plus registered read.
  always_ff @(posedge clk) begin
    if (we0) begin
      mem_q[addr0] <= data0;
    end
    q0 <= mem_q[addr0];
  end

  // Port 1: registered lookup read.
  always_ff @(posedge clk) begin
    q1 <= mem_q[addr1];
  end

endmodule

// File: rtl/jtvigil_colmix.sv
// Colour mixer: picks the visible layer, reads R/G/B from the palette RAM over
// four clocks after each pixel enable, and drives blanked RGB one pixel later.
module jtvigil_colmix
  import jtvigil_colmix_pkg::*;
#(
  parameter string SIMFILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pxl_cen,
  input  logic [10:0] main_addr,
  input  logic [7:0]  main_dout,
  output logic [7:0]  main_din,
  input  logic        main_rnw,
  input  logic        pal_cs,
  input  logic [7:0]  scr1_pxl,
  input  logic [6:0]  scr2_pxl,
  input  logic [6:0]  obj_pxl,
  input  logic        scr2_en,
  input  logic        LHBL,
  input  logic        LVBL,
  output logic [4:0]  red,
  output logic [4:0]  green,
  output logic [4:0]  blue,
  output logic        LHBL_dly,
  output logic        LVBL_dly
);

  state_e      state_q, state_d;
  logic [8:0]  idx_s, idx_q, rd_idx_s;
  logic        lhbl_q, lvbl_q;
  logic [10:0] rd_addr_q;
  logic [1:0]  rd_ch_s;
  logic        addr_ld_s, cap_r_s, cap_g_s, cap_b_s;
  logic [4:0]  cap_r_q, cap_g_q, cap_b_q;
  logic [4:0]  red_q, green_q, blue_q;
  logic        lhbl_dly_q, lvbl_dly_q;
  logic        cpu_we_s, rd_ch3_q;
  logic [7:0]  cpu_q_s, lk_q_s;
  logic        unused_lk_s;

  assign idx_s       = pick_index(scr1_pxl, scr2_pxl, obj_pxl, scr2_en);
  assign rd_idx_s    = pxl_cen ? idx_s : idx_q;
  assign cpu_we_s    = pal_cs & ~main_rnw & (main_addr[10:9] != CH_NONE);
  assign main_din    = rd_ch3_q ? 8'hFF : cpu_q_s;
  assign unused_lk_s = &{1'b0, lk_q_s[7:5]};

  jtframe_dual_ram #(.AW(11), .DW(8)) u_ram (
    .clk   (clk),
    .data0 (main_dout),
    .addr0 (main_addr),
    .we0   (cpu_we_s),
    .q0    (cpu_q_s),
    .addr1 (rd_addr_q),
    .q1    (lk_q_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a pixel enable always restarts the lookup.
  always_comb begin
    state_d = state_q;
    if (pxl_cen) begin
      state_d = RD_R;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RD_R:    state_d = RD_G;
        RD_G:    state_d = RD_B;
        RD_B:    state_d = CAP_B;
        CAP_B:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: read address channel and capture strobes (data lags address by 2 clk).
  always_comb begin
    addr_ld_s = 1'b0;
    rd_ch_s   = CH_R;
    cap_r_s   = 1'b0;
    cap_g_s   = 1'b0;
    cap_b_s   = 1'b0;
    if (pxl_cen) begin
      addr_ld_s = 1'b1;
      rd_ch_s   = CH_R;
    end else begin
      case (state_q)
        RD_R: begin
          addr_ld_s = 1'b1;
          rd_ch_s   = CH_G;
        end
        RD_G: begin
          cap_r_s   = 1'b1;
          addr_ld_s = 1'b1;
          rd_ch_s   = CH_B;
        end
        RD_B:    cap_g_s = 1'b1;
        CAP_B:   cap_b_s = 1'b1;
        default: addr_ld_s = 1'b0;
      endcase
    end
  end

  // Datapath: pixel latches, lookup address, channel captures, blanked outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q      <= 9'd0;
      lhbl_q     <= 1'b0;
      lvbl_q     <= 1'b0;
      rd_addr_q  <= 11'd0;
      cap_r_q    <= 5'd0;
      cap_g_q    <= 5'd0;
      cap_b_q    <= 5'd0;
      red_q      <= 5'd0;
      green_q    <= 5'd0;
      blue_q     <= 5'd0;
      lhbl_dly_q <= 1'b0;
      lvbl_dly_q <= 1'b0;
      rd_ch3_q   <= 1'b0;
    end else begin
      rd_ch3_q <= (main_addr[10:9] == CH_NONE);
      if (pxl_cen) begin
        red_q      <= (lhbl_q & lvbl_q) ? cap_r_q : 5'd0;
        green_q    <= (lhbl_q & lvbl_q) ? cap_g_q : 5'd0;
        blue_q     <= (lhbl_q & lvbl_q) ? cap_b_q : 5'd0;
        lhbl_dly_q <= lhbl_q;
        lvbl_dly_q <= lvbl_q;
        idx_q      <= idx_s;
        lhbl_q     <= LHBL;
        lvbl_q     <= LVBL;
      end
      if (addr_ld_s) begin
        rd_addr_q <= {rd_ch_s, rd_idx_s};
      end
      if (cap_r_s) begin
        cap_r_q <= lk_q_s[4:0];
      end
      if (cap_g_s) begin
        cap_g_q <= lk_q_s[4:0];
      end
      if (cap_b_s) begin
        cap_b_q <= lk_q_s[4:0];
      end
    end
  end

  assign red      = red_q;
  assign green    = green_q;
  assign blue     = blue_q;
  assign LHBL_dly = lhbl_dly_q;
  assign LVBL_dly = lvbl_dly_q;

endmodule

// File: tb/tb_jtvigil_colmix.sv
// Self-checking bench for jtvigil_colmix: palette/priority model with a
// per-cycle output compare, plus literal checks of the key scenarios.
module tb_jtvigil_colmix;

  logic        clk = 1'b0;
  logic        rst, pxl_cen, main_rnw, pal_cs, scr2_en, LHBL, LVBL;
  logic [10:0] main_addr;
  logic [7:0]  main_dout, main_din, scr1_pxl;
  logic [6:0]  scr2_pxl, obj_pxl;
  logic [4:0]  red, green, blue;
  logic        LHBL_dly, LVBL_dly;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Model: palette copy, pixel waiting for display, and what is displayed now.
  logic [7:0] pal_m [0:2047];
  logic [4:0] pend_r, pend_g, pend_b, show_r, show_g, show_b;
  logic       pend_lh, pend_lv, show_lh, show_lv;

  always #5 clk = ~clk;

  jtvigil_colmix #(.SIMFILE("")) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .main_addr(main_addr),
    .main_dout(main_dout), .main_din(main_din), .main_rnw(main_rnw),
    .pal_cs(pal_cs), .scr1_pxl(scr1_pxl), .scr2_pxl(scr2_pxl),
    .obj_pxl(obj_pxl), .scr2_en(scr2_en), .LHBL(LHBL), .LVBL(LVBL),
    .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_index(input int s1, input int s2, input int o, input bit en);
    if ((o % 16) != 15) return 256 + o;
    if ((s1 % 16) != 0) return s1;
    if (en) return 384 + s2;
    return 384;
  endfunction

  always @(posedge clk) begin
    int idx;
    logic [7:0] v;
    if (pal_cs && !main_rnw && (main_addr / 512) != 3) pal_m[main_addr] = main_dout;
    if (rst) begin
      {pend_r, pend_g, pend_b, pend_lh, pend_lv} = '0;
      {show_r, show_g, show_b, show_lh, show_lv} = '0;
    end else if (pxl_cen) begin
      show_r  = (pend_lh && pend_lv) ? pend_r : 5'd0;
      show_g  = (pend_lh && pend_lv) ? pend_g : 5'd0;
      show_b  = (pend_lh && pend_lv) ? pend_b : 5'd0;
      show_lh = pend_lh;
      show_lv = pend_lv;
      idx = model_index(int'(scr1_pxl), int'(scr2_pxl), int'(obj_pxl), scr2_en);
      v = pal_m[idx];        pend_r = v[4:0];
      v = pal_m[idx + 512];  pend_g = v[4:0];
      v = pal_m[idx + 1024]; pend_b = v[4:0];
      pend_lh = LHBL;
      pend_lv = LVBL;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("red", red, show_r);
      check("green", green, show_g);
      check("blue", blue, show_b);
      check("LHBL_dly", LHBL_dly, show_lh);
      check("LVBL_dly", LVBL_dly, show_lv);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    main_addr = a; main_dout = d; pal_cs = 1'b1; main_rnw = 1'b0;
    tick();
    pal_cs = 1'b0; main_rnw = 1'b1;
  endtask

  task automatic cpu_read(input string name, input logic [10:0] a, input logic [7:0] exp);
    main_addr = a; pal_cs = 1'b1; main_rnw = 1'b1;
    tick();
    check(name, main_din, exp);
    pal_cs = 1'b0;
  endtask

  // One pixel: enable pulse, lookup time, then an optional random CPU write.
  task automatic pixel(input logic [7:0] s1, input logic [6:0] s2, input logic [6:0] o,
                       input logic en, input logic lh, input logic lv, input bit wr);
    scr1_pxl = s1; scr2_pxl = s2; obj_pxl = o; scr2_en = en; LHBL = lh; LVBL = lv;
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    repeat (4) tick();
    if (wr) begin
      main_addr = 11'($urandom_range(0, 2047)); main_dout = 8'($urandom);
      pal_cs = 1'b1; main_rnw = 1'b0;
    end
    tick();
    pal_cs = 1'b0; main_rnw = 1'b1;
  endtask

  task automatic check_rgb(input string name, input logic [4:0] r, input logic [4:0] g, input logic [4:0] b);
    check({name, "_r"}, red, r);
    check({name, "_g"}, green, g);
    check({name, "_b"}, blue, b);
  endtask

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; main_rnw = 1'b1; pal_cs = 1'b0; scr2_en = 1'b1;
    LHBL = 1'b0; LVBL = 1'b0; main_addr = 11'd0; main_dout = 8'd0;
    scr1_pxl = 8'd0; scr2_pxl = 7'd0; obj_pxl = 7'd0;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check_rgb("reset", 5'd0, 5'd0, 5'd0);
    check("reset_lhbl", LHBL_dly, 1'b0);
    check("reset_lvbl", LVBL_dly, 1'b0);

    for (int a = 0; a < 1536; a++) cpu_write(11'(a), 8'($urandom));

    cpu_write(11'h013, 8'h1F); cpu_write(11'h213, 8'hE0); cpu_write(11'h413, 8'h0A);
    cpu_write(11'h125, 8'h03); cpu_write(11'h325, 8'h11); cpu_write(11'h525, 8'h1C);
    cpu_write(11'h187, 8'h05); cpu_write(11'h387, 8'h06); cpu_write(11'h587, 8'h07);
    cpu_write(11'h180, 8'h18); cpu_write(11'h380, 8'h19); cpu_write(11'h580, 8'h1A);

    pixel(8'h13, 7'h00, 7'h0F, 1'b1, 1'b1, 1'b1, 1'b0);
    pixel(8'h13, 7'h00, 7'h25, 1'b1, 1'b1, 1'b1, 1'b0);
    check_rgb("scr1_013", 5'h1F, 5'h00, 5'h0A);
    pixel(8'h10, 7'h07, 7'h0F, 1'b1, 1'b1, 1'b1, 1'b0);
    check_rgb("obj_125", 5'h03, 5'h11, 5'h1C);
    pixel(8'h10, 7'h07, 7'h0F, 1'b0, 1'b1, 1'b1, 1'b0);
    check_rgb("scr2_187", 5'h05, 5'h06, 5'h07);
    pixel(8'h13, 7'h00, 7'h0F, 1'b1, 1'b1, 1'b0, 1'b0);
    check_rgb("scr2_off_180", 5'h18, 5'h19, 5'h1A);
    pixel(8'h13, 7'h00, 7'h0F, 1'b1, 1'b1, 1'b1, 1'b0);
    check_rgb("vblank", 5'd0, 5'd0, 5'd0);
    check("vblank_lvbl", LVBL_dly, 1'b0);
    check("vblank_lhbl", LHBL_dly, 1'b1);

    cpu_write(11'h613, 8'h55);
    cpu_read("read_ch3", 11'h613, 8'hFF);
    cpu_read("read_213", 11'h213, 8'hE0);
    pixel(8'h13, 7'h00, 7'h0F, 1'b1, 1'b1, 1'b1, 1'b0);
    check_rgb("ch3_no_effect", 5'h1F, 5'h00, 5'h0A);

    // Reset while the lookup is in RD_G.
    scr1_pxl = 8'h13; obj_pxl = 7'h25; LHBL = 1'b1; LVBL = 1'b1;
    pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_rgb("rst_mid", 5'd0, 5'd0, 5'd0);
    check("rst_mid_lhbl", LHBL_dly, 1'b0);
    check("rst_mid_lvbl", LVBL_dly, 1'b0);
    repeat (3) tick();
    pixel(8'h13, 7'h00, 7'h0F, 1'b1, 1'b1, 1'b1, 1'b0);
    check_rgb("post_rst_1", 5'd0, 5'd0, 5'd0);
    pixel(8'h13, 7'h00, 7'h0F, 1'b1, 1'b1, 1'b1, 1'b0);
    check_rgb("post_rst_2", 5'h1F, 5'h00, 5'h0A);
    check("post_rst_lhbl", LHBL_dly, 1'b1);

    for (int n = 0; n < 400; n++) begin
      logic [7:0] s1;
      logic [6:0] o;
      s1 = 8'($urandom);
      o  = 7'($urandom);
      if ($urandom_range(0, 1) == 0) s1[3:0] = 4'h0;
      if ($urandom_range(0, 1) == 0) o[3:0] = 4'hF;
      pixel(s1, 7'($urandom), o, 1'($urandom), 1'($urandom_range(0, 7) != 0),
            1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jtvigil_colmix.md
# jtvigil_colmix

Colour mixer and palette stage downstream of the foreground tilemap (scr1), background (scr2) and sprite (obj) pixel generators. Each pixel it picks the visible layer by fixed priority, looks the pixel up in a CPU-writable palette held as three 5-bit channel tables in one RAM, and drives registered RGB with blanking applied. Its output feeds the video output stage directly.

## Interface
Parameters:
- SIMFILE, "", optional palette RAM preload file for simulation

Ports:
- clk  in  1  system clock; only clock in the block
- rst  in  1  synchronous, active-high reset
- pxl_cen  in  1  pixel clock enable; pulses are spaced at least 5 clk apart
- main_addr  in  11  CPU palette address: [10:9] channel (0 R, 1 G, 2 B, 3 unmapped), [8:0] entry
- main_dout  in  8  CPU write data; bits [4:0] are used by the lookup
- main_din  out  8  CPU read data, one clk after the address
- main_rnw  in  1  CPU read-not-write
- pal_cs  in  1  palette chip select
- scr1_pxl  in  8  {pal[3:0], col[3:0]} from the foreground tilemap
- scr2_pxl  in  7  {pal[2:0], col[3:0]} from the background
- obj_pxl  in  7  {pal[2:0], col[3:0]} from sprites
- scr2_en  in  1  background layer enable
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- red, green, blue  out  5 each  colour output
- LHBL_dly, LVBL_dly  out  1 each  blanking delayed to match the RGB outputs

## Operation
- Transparency: obj is transparent when col==4'hF. scr1 is transparent when col==4'h0. scr2 is never transparent, but is replaced by index 0x180 when scr2_en=0.
- Priority: opaque obj, then opaque scr1, then scr2.
- Palette index (9 bits): obj gives {2'b10, obj_pxl}, scr1 gives {1'b0, scr1_pxl}, scr2 gives {2'b11, scr2_pxl}.
- CPU write: when pal_cs & ~main_rnw, main_dout is written at main_addr. Writes are ignored when main_addr[10:9]==3.
- CPU read: main_din is the RAM data, or 8'hFF for channel 3.
- Lookup FSM states: IDLE, RD_R, RD_G, RD_B, CAP_B.
  - On pxl_cen: latch the index, LHBL and LVBL; present read address {2'd0, idx}; go to RD_R.
  - RD_R: address G; go to RD_G.
  - RD_G: capture R from the RAM output; address B; go to RD_B.
  - RD_B: capture G; go to CAP_B.
  - CAP_B: capture B; go to IDLE.
- Output update on each pxl_cen:
  - red/green/blue load the captured channels, or 0 when the previously latched LHBL or LVBL is low.
  - LHBL_dly/LVBL_dly load the previously latched blanking bits.
- pxl_cen in a non-IDLE state (spacing violation): the outputs load the captures as they stand, and the FSM restarts at RD_R with the new index. No lockup.
- Simultaneous CPU write and lookup of the same entry: the lookup returns either the old or the new value. The RAM is dual-port, so the CPU is never stalled.

## Timing
- Pixel latency: inputs sampled at pxl_cen k appear on red/green/blue at pxl_cen k+1, i.e. one pixel.
- FSM busy for 4 clk after each pxl_cen.
- Palette RAM: synchronous read, 1 clk latency on both ports.
- Reset values:
  - red, green, blue: 0
  - LHBL_dly, LVBL_dly: 0
  - FSM: IDLE
  - captures and latched index: 0
  - latched blanking bits: 0
  - RAM contents: unaffected
- Reset asserted mid-sequence: FSM to IDLE on the next clk. The first pxl_cen after reset outputs black.

## Structure
- Package jtvigil_colmix_pkg holds:
  - FSM state enum
  - channel codes CH_R/CH_G/CH_B
  - layer base constants OBJ_BASE=9'h100, SCR2_BASE=9'h180
  - transparency codes OBJ_TRANSP=4'hF, SCR1_TRANSP=4'h0
- Single sub-module: jtframe_dual_ram, aw=11, dw=8. Port 0 is the CPU; port 1 is the lookup. Both ports are on clk.

## Test plan
- Write R/G/B for entry 0x013 = 5'h1F/5'h00/5'h0A. Drive scr1_pxl=8'h13, obj_pxl col=F, blanking high. At pxl_cen+1: RGB = 1F/00/0A.
- Opaque obj 7'h25 over opaque scr1. Output equals palette entry 0x125; scr1 entry is ignored.
- scr1 col=0, obj col=F, scr2_pxl=7'h07. Output equals entry 0x187. With scr2_en=0 the output equals entry 0x180.
- LVBL low at pxl_cen k. RGB=0 and LVBL_dly=0 at pxl_cen k+1, even with a non-black palette.
- CPU read of 0x613 after writes returns 8'hFF. A write to 0x613 changes no RGB table entry. A read of 0x213 returns the written byte one clk later.
- rst pulsed during RD_G. All outputs 0, FSM IDLE. The next two pxl_cen with a valid pixel produce correct RGB on the second pulse.
